pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, meaning the datapath payload width (operands plus immediate).
REQ-002 SHALL have parameter CTRL_W, default 16, meaning the control payload width (regWrite, memWrite and similar bits).
REQ-003 SHALL have parameter CNT_W, default 16, meaning the bubble counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream stage presents a valid instruction.
REQ-007 SHALL have port in_ready, output, 1 bit: this stage accepts the input this cycle.
REQ-008 SHALL have port in_ctrl, input, CTRL_W bits: upstream control bits.
REQ-009 SHALL have port in_data, input, DATA_W bits: upstream datapath payload.
REQ-010 SHALL have port flush, input, 1 bit: synchronous kill of all held contents (branch/jump squash).
REQ-011 SHALL have port out_valid, output, 1 bit: the output holds a valid instruction.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream stage consumes the output this cycle.
REQ-013 SHALL have port out_ctrl, output, CTRL_W bits: registered control bits.
REQ-014 SHALL have port out_data, output, DATA_W bits: registered datapath payload.
REQ-015 SHALL have port bubble_cnt, output, CNT_W bits: saturating count of cycles with out_valid=0.

Function
REQ-016 SHALL define a handshake: an input transfer occurs when in_valid and in_ready are both 1; an output transfer occurs when out_valid and out_ready are both 1.
REQ-017 SHALL present a transferred input on out_* exactly 1 cycle after acceptance when the stage was empty or drained in the same cycle.
REQ-018 SHALL hold out_valid, out_ctrl and out_data stable while out_valid=1 and out_ready=0 (stall); no payload may be lost or duplicated.
REQ-019 SHALL force out_ctrl to all-zero whenever out_valid=0, so that bubbles are NOPs.
REQ-020 SHALL, without skid, use states EMPTY and FULL.
REQ-021 SHALL, without skid, make in_ready combinational: in_ready = !out_valid | out_ready.
REQ-022 SHALL, without skid, transition EMPTY->FULL on an input transfer.
REQ-023 SHALL, without skid, keep FULL->FULL on a simultaneous input and output transfer.
REQ-024 SHALL, without skid, transition FULL->EMPTY on an output transfer with no input transfer.
REQ-025 SHALL give flush priority over all handshakes: the next state is EMPTY, out_valid=0 and out_ctrl=0, and any input accepted in the flush cycle is discarded.
REQ-026 SHALL increment bubble_cnt by 1 on each clock edge where out_valid=0, saturating at all-ones (no wrap-around).
REQ-027 SHALL leave bubble_cnt unaffected by flush.

Reset
REQ-028 SHALL, while rst=0, immediately set the state to EMPTY with out_valid=0, out_ctrl=0, out_data=0 and bubble_cnt=0, and drop any held payload, including a payload caught mid-stall.
REQ-029 SHALL, while rst=0, drive in_ready=1 without skid and in_ready=0 with skid.
REQ-030 SHALL make in_ready=1 on the first clock edge after release when built with skid.

Configuration
REQ-031 SHALL, when macro PIPE_STAGE_SKID_EN is defined, add a second (skid) entry and make in_ready a registered signal equal to "skid entry empty".
REQ-032 SHALL, with PIPE_STAGE_SKID_EN, use states EMPTY, FULL and SKID: FULL->SKID on an input transfer while out_ready=0; SKID->FULL on an output transfer, with the skid entry moving to the output on the next cycle; SKID accepts no input.
REQ-033 SHALL, with PIPE_STAGE_SKID_EN, make flush clear both entries.
REQ-034 SHALL, without PIPE_STAGE_SKID_EN, have no skid storage and keep in_ready combinational as in REQ-021.

Structure
REQ-035 SHALL place the state encoding (EMPTY/FULL/SKID) and the default widths in the shared package pipe_pkg.
REQ-036 SHALL use one sub-module, pipe_skid_buf, which holds the skid entry and is instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-037 SHALL cover basic transfer: in_valid=1, in_ctrl=16'h00A5, in_data=96'h1234, out_ready=1 -> out_valid=1 and out_ctrl=16'h00A5 on the next edge, with in_ready=1 throughout.
REQ-038 SHALL cover stall: a payload held with out_ready=0 for 5 cycles -> out_* unchanged for all 5 cycles; without skid in_ready=0; with skid the 2nd input is accepted, then in_ready=0.
REQ-039 SHALL cover flush: flush=1 in the same cycle as an input transfer while FULL -> next cycle out_valid=0 and out_ctrl=0, and the input is never emitted.
REQ-040 SHALL cover back-to-back streaming: 8 inputs with out_ready=1 continuously -> 8 outputs in order, one per cycle, with no bubbles after the first.
REQ-041 SHALL cover bubble_cnt saturation: CNT_W=4 and 20 idle cycles -> bubble_cnt=4'hF, held.
REQ-042 SHALL cover reset mid-stall: rst=0 asserted asynchronously while FULL -> out_valid=0 and bubble_cnt=0 before the next clk edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default widths for pipe_stage_reg
package pipe_pkg;

  localparam int DATA_W_DEF = 96;
  localparam int CTRL_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - second (skid) entry holding one control/data payload
module pipe_skid_buf #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic [CTRL_W-1:0] skid_ctrl,
  output logic [DATA_W-1:0] skid_data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (clear) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (load) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with flush and bubble counter
// Optional skid entry and registered in_ready when PIPE_STAGE_SKID_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              in_xfer;
  logic              out_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  // Bubbles must look like NOPs downstream regardless of what ctrl_q holds.
  assign out_ctrl  = out_valid ? ctrl_q : '0;
  assign out_data  = data_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              in_ready_q;
  logic              skid_load;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready = in_ready_q;

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (flush),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .skid_ctrl (skid_ctrl),
    .skid_data (skid_data)
  );

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    skid_load = 1'b0;
    case (state_q)
      ST_EMPTY: if (in_xfer) begin
        state_d = ST_FULL;
        ctrl_d  = in_ctrl;
        data_d  = in_data;
      end
      ST_FULL: begin
        if (in_xfer && out_ready) begin
          ctrl_d = in_ctrl;
          data_d = in_data;
        end else if (in_xfer) begin
          state_d   = ST_SKID;
          skid_load = 1'b1;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: if (out_xfer) begin
        state_d = ST_FULL;
        ctrl_d  = skid_ctrl;
        data_d  = skid_data;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d   = ST_EMPTY;
      skid_load = 1'b0;
    end
  end

  // in_ready reflects "skid entry empty" for the coming cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_ready_q <= 1'b0;
    else      in_ready_q <= (state_d != ST_SKID);
  end
`else
  assign in_ready = !out_valid | out_ready;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (in_xfer) begin
      state_d = ST_FULL;
      ctrl_d  = in_ctrl;
      data_d  = in_data;
    end else if (out_xfer) begin
      state_d = ST_EMPTY;
    end
    if (flush) state_d = ST_EMPTY;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      ctrl_q     <= '0;
      data_q     <= '0;
      bubble_cnt <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      if (!out_valid && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
